// File: rtl/mult_seq_pkg.sv
// Shared types and widths for the normalising multiplier sequencer.
package mult_seq_pkg;

  localparam int SHCNT_W = 5;
  localparam int PAIR_W  = 3;
  localparam int GUARD_W = 4;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    RD_A,
    LD_A,
    NORM_A,
    RD_B,
    LD_B,
    NORM_B,
    MUL,
    LDO,
    SHR,
    WR,
    NEXT,
    DONE
  } state_e;

endpackage

// File: rtl/norm_guard_counter.sv
// Bounds the normalise loop: counts shifts of one operand and flags MAX_NORM.
module norm_guard_counter
  import mult_seq_pkg::*;
#(
  parameter int MAX_NORM = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_term
);

  logic [GUARD_W-1:0] r_count;

  assign o_term = (r_count == GUARD_W'(MAX_NORM));

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_term) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/mult_seq_controller.sv
// Sequencer for the normalising multiplier: fetch, normalise, multiply,
// denormalise and write back each operand pair held in the input RAM.
module mult_seq_controller
  import mult_seq_pkg::*;
#(
  parameter int PAIRS    = 8,
  parameter int MAX_NORM = 15,
  parameter int RAM_LAT  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic Co3,
  input  logic DoneA,
  input  logic DoneB,
  input  logic down_done,
  output logic read,
  output logic write,
  output logic rst3,
  output logic cnt3,
  output logic SA,
  output logic SB,
  output logic loadA,
  output logic ShlA,
  output logic loadB,
  output logic ShlB,
  output logic rst5,
  output logic cntU,
  output logic cntD,
  output logic loadOut,
  output logic ShrOut,
  output logic busy,
  output logic done,
  output logic zero_flag
);

  localparam int               LAT_W    = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RAM_LAT - 1);

  if (PAIRS != (1 << PAIR_W)) begin : g_bad_pairs
    $error("PAIRS must equal 2**PAIR_W of the datapath pair counter");
  end

  state_e           r_state;
  logic [LAT_W-1:0] r_lat;
  logic             r_zero_flag;
  logic             w_guard_term;

  // One guard serves both operands: it is cleared on every operand load.
  norm_guard_counter #(
    .MAX_NORM(MAX_NORM)
  ) u_guard (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (loadA | loadB),
    .i_inc (ShlA | ShlB),
    .o_term(w_guard_term)
  );

  assign zero_flag = r_zero_flag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_lat       <= '0;
      r_zero_flag <= 1'b0;
    end else begin
      case (r_state)
        IDLE:   if (start) r_state <= INIT;
        INIT: begin
          r_zero_flag <= 1'b0;
          r_state     <= RD_A;
        end
        RD_A, RD_B: begin
          if (r_lat == LAT_LAST) begin
            r_lat   <= '0;
            r_state <= (r_state == RD_A) ? LD_A : LD_B;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        LD_A:   r_state <= NORM_A;
        LD_B:   r_state <= NORM_B;
        NORM_A: begin
          if (DoneA) begin
            r_state <= RD_B;
          end else if (w_guard_term) begin
            r_zero_flag <= 1'b1;
            r_state     <= RD_B;
          end
        end
        NORM_B: begin
          if (DoneB) begin
            r_state <= MUL;
          end else if (w_guard_term) begin
            r_zero_flag <= 1'b1;
            r_state     <= MUL;
          end
        end
        MUL:    r_state <= LDO;
        LDO:    r_state <= SHR;
        SHR:    if (down_done) r_state <= WR;
        WR:     r_state <= NEXT;
        NEXT:   r_state <= Co3 ? DONE : RD_A;
        DONE:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Control strobes follow the state in the same cycle; the datapath qualifiers
  // gate the shift strobes so the loop stops the moment an operand is normalised.
  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    read    = 1'b0;
    write   = 1'b0;
    rst3    = 1'b0;
    cnt3    = 1'b0;
    SA      = 1'b0;
    SB      = 1'b0;
    loadA   = 1'b0;
    ShlA    = 1'b0;
    loadB   = 1'b0;
    ShlB    = 1'b0;
    rst5    = 1'b0;
    cntU    = 1'b0;
    cntD    = 1'b0;
    loadOut = 1'b0;
    ShrOut  = 1'b0;
    done    = 1'b0;
    busy    = (r_state != IDLE);
    case (r_state)
      INIT: begin
        rst3 = 1'b1;
        rst5 = 1'b1;
      end
      RD_A: begin
        read = 1'b1;
        SA   = 1'b1;
      end
      LD_A: begin
        SA    = 1'b1;
        loadA = 1'b1;
      end
      NORM_A: begin
        if (!DoneA && !w_guard_term) begin
          ShlA = 1'b1;
          cntU = 1'b1;
        end
      end
      RD_B: begin
        read = 1'b1;
        SB   = 1'b1;
      end
      LD_B: begin
        SB    = 1'b1;
        loadB = 1'b1;
      end
      NORM_B: begin
        if (!DoneB && !w_guard_term) begin
          ShlB = 1'b1;
          cntU = 1'b1;
        end
      end
      LDO:  loadOut = 1'b1;
      SHR: begin
        if (!down_done) begin
          ShrOut = 1'b1;
          cntD   = 1'b1;
        end
      end
      WR:   write = 1'b1;
      NEXT: begin
        if (!Co3) begin
          cnt3 = 1'b1;
          rst5 = 1'b1;
        end
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
